// File: rtl/uart_mem_loader_if.sv
// UART byte stream, CPU handshake and port-b signals of the instruction RAM and image memory.
interface uart_mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_done;
    logic        load_done;
    logic        dump_done;
    logic [7:0]  M_I_data_UART;
    logic [7:0]  M_I_addr_UART;
    logic        M_I_we_UART;
    logic [7:0]  MI_IMG_data_UART;
    logic [18:0] MI_IMG_addr_UART;
    logic        MI_IMG_we_UART;
    logic [7:0]  MI_IMG_q_UART;

    modport master (
        input  rx_data, rx_valid, tx_ready, cpu_done, MI_IMG_q_UART,
        output tx_data, tx_valid, load_done, dump_done,
               M_I_data_UART, M_I_addr_UART, M_I_we_UART,
               MI_IMG_data_UART, MI_IMG_addr_UART, MI_IMG_we_UART
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, cpu_done, MI_IMG_q_UART,
        input  tx_data, tx_valid, load_done, dump_done,
               M_I_data_UART, M_I_addr_UART, M_I_we_UART,
               MI_IMG_data_UART, MI_IMG_addr_UART, MI_IMG_we_UART
    );
endinterface

// File: rtl/uart_mem_loader.sv
// Loads program and input image from UART into memory, then streams the result image back out.
// Optional UART_DUMP_CHECKSUM_EN appends a mod-256 sum byte after the dumped data.
module uart_mem_loader #(
    parameter int unsigned INS_BYTES     = 256,
    parameter int unsigned IMG_IN_BYTES  = 65536,
    parameter int unsigned IMG_OUT_BASE  = 65536,
    parameter int unsigned IMG_OUT_BYTES = 16384,
    parameter int unsigned RD_LAT        = 2
) (
    input logic             clk,
    input logic             rst_n,
    uart_mem_loader_if.master bus
);

    localparam int unsigned LAT_W = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        IDLE, LOAD_INS, LOAD_IMG, WAIT_CPU, DUMP_RD, DUMP_TX,
`ifdef UART_DUMP_CHECKSUM_EN
        DUMP_SUM,
`endif
        FIN
    } state_t;

    state_t            state, state_nxt;
    logic [18:0]       cnt, cnt_nxt;
    logic [LAT_W-1:0]  lat, lat_nxt;
    logic [7:0]        tx_data, tx_data_nxt;
    logic              tx_valid, tx_valid_nxt;
    logic              load_done, load_done_nxt;
    logic              dump_done, dump_done_nxt;
    logic [7:0]        i_data, i_data_nxt;
    logic [7:0]        i_addr, i_addr_nxt;
    logic              i_we, i_we_nxt;
    logic [7:0]        img_data, img_data_nxt;
    logic [18:0]       img_addr, img_addr_nxt;
    logic              img_we, img_we_nxt;
`ifdef UART_DUMP_CHECKSUM_EN
    logic [7:0]        sum, sum_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            load_done <= 1'b0;
            dump_done <= 1'b0;
            i_data    <= '0;
            i_addr    <= '0;
            i_we      <= 1'b0;
            img_data  <= '0;
            img_addr  <= '0;
            img_we    <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat       <= lat_nxt;
            tx_data   <= tx_data_nxt;
            tx_valid  <= tx_valid_nxt;
            load_done <= load_done_nxt;
            dump_done <= dump_done_nxt;
            i_data    <= i_data_nxt;
            i_addr    <= i_addr_nxt;
            i_we      <= i_we_nxt;
            img_data  <= img_data_nxt;
            img_addr  <= img_addr_nxt;
            img_we    <= img_we_nxt;
`ifdef UART_DUMP_CHECKSUM_EN
            sum       <= sum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lat_nxt      = lat;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        i_data_nxt   = i_data;
        i_addr_nxt   = i_addr;
        i_we_nxt     = 1'b0;
        img_data_nxt = img_data;
        img_addr_nxt = img_addr;
        img_we_nxt   = 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
        sum_nxt      = sum;
`endif
        case (state)
            // IDLE shares the write path: its first byte is instruction byte 0 (cnt is 0 here).
            IDLE, LOAD_INS: begin
                if (bus.rx_valid) begin
                    i_addr_nxt = cnt[7:0];
                    i_data_nxt = bus.rx_data;
                    i_we_nxt   = 1'b1;
                    if (cnt == 19'(INS_BYTES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_IMG;
                    end else begin
                        cnt_nxt   = cnt + 19'd1;
                        state_nxt = LOAD_INS;
                    end
                end
            end
            LOAD_IMG: begin
                if (bus.rx_valid) begin
                    img_addr_nxt = cnt;
                    img_data_nxt = bus.rx_data;
                    img_we_nxt   = 1'b1;
                    if (cnt == 19'(IMG_IN_BYTES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = WAIT_CPU;
                    end else begin
                        cnt_nxt   = cnt + 19'd1;
                    end
                end
            end
            WAIT_CPU: begin
                if (bus.cpu_done) begin
                    cnt_nxt      = '0;
                    lat_nxt      = '0;
                    img_addr_nxt = 19'(IMG_OUT_BASE);
`ifdef UART_DUMP_CHECKSUM_EN
                    sum_nxt      = '0;
`endif
                    state_nxt    = DUMP_RD;
                end
            end
            // lat counts cycles since the read address became visible on the port.
            DUMP_RD: begin
                if (lat == LAT_W'(RD_LAT)) begin
                    tx_data_nxt  = bus.MI_IMG_q_UART;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = DUMP_TX;
                end else begin
                    lat_nxt = lat + 1'b1;
                end
            end
            DUMP_TX: begin
                if (bus.tx_ready) begin
                    tx_valid_nxt = 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
                    sum_nxt = sum + tx_data;
`endif
                    if (cnt == 19'(IMG_OUT_BYTES - 1)) begin
`ifdef UART_DUMP_CHECKSUM_EN
                        tx_data_nxt  = sum + tx_data;
                        tx_valid_nxt = 1'b1;
                        state_nxt    = DUMP_SUM;
`else
                        state_nxt    = FIN;
`endif
                    end else begin
                        cnt_nxt      = cnt + 19'd1;
                        lat_nxt      = '0;
                        img_addr_nxt = 19'(IMG_OUT_BASE) + cnt + 19'd1;
                        state_nxt    = DUMP_RD;
                    end
                end
            end
`ifdef UART_DUMP_CHECKSUM_EN
            DUMP_SUM: begin
                if (bus.tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = FIN;
                end
            end
`endif
            FIN: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        load_done_nxt = (state_nxt == WAIT_CPU);
        dump_done_nxt = (state_nxt == FIN);
    end

    assign bus.tx_data          = tx_data;
    assign bus.tx_valid         = tx_valid;
    assign bus.load_done        = load_done;
    assign bus.dump_done        = dump_done;
    assign bus.M_I_data_UART    = i_data;
    assign bus.M_I_addr_UART    = i_addr;
    assign bus.M_I_we_UART      = i_we;
    assign bus.MI_IMG_data_UART = img_data;
    assign bus.MI_IMG_addr_UART = img_addr;
    assign bus.MI_IMG_we_UART   = img_we;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: memory models, load/dump scenarios, tx handshake monitor.
// Define UART_DUMP_CHECKSUM_EN for both bench and RTL to cover the checksum byte.
module tb_uart_mem_loader;

    localparam int INS_BYTES     = 4;
    localparam int IMG_IN_BYTES  = 8;
    localparam int IMG_OUT_BASE  = 16;
    localparam int IMG_OUT_BYTES = 4;
    localparam int RD_LAT        = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_mem_loader_if bus();

    uart_mem_loader #(
        .INS_BYTES(INS_BYTES), .IMG_IN_BYTES(IMG_IN_BYTES), .IMG_OUT_BASE(IMG_OUT_BASE),
        .IMG_OUT_BYTES(IMG_OUT_BYTES), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] ins_mem [0:3];
    logic [7:0] img_mem [0:31];
    logic [7:0] rd_p1 = 8'h00;
    int         oob_wr = 0;
    int         ins_we_cyc = 0;
    int         img_we_cyc = 0;
    logic [7:0] tx_q [$];
    bit         bp_mode = 1'b0;
    int         hold = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory models: synchronous write, RD_LAT-cycle registered read.
    always @(posedge clk) begin
        if (bus.M_I_we_UART === 1'b1) begin
            if (bus.M_I_addr_UART < 8'd4) ins_mem[bus.M_I_addr_UART[1:0]] = bus.M_I_data_UART;
            else oob_wr++;
        end
        if (bus.MI_IMG_we_UART === 1'b1) begin
            if (bus.MI_IMG_addr_UART < 19'd32) img_mem[bus.MI_IMG_addr_UART[4:0]] = bus.MI_IMG_data_UART;
            else oob_wr++;
        end
        bus.MI_IMG_q_UART <= rd_p1;
        rd_p1 = (bus.MI_IMG_addr_UART < 19'd32) ? img_mem[bus.MI_IMG_addr_UART[4:0]] : 8'h00;
    end

    // Write-strobe counting, tx_ready policy and tx handshake checks.
    always @(negedge clk) begin
        if (bus.M_I_we_UART === 1'b1) ins_we_cyc++;
        if (bus.MI_IMG_we_UART === 1'b1) img_we_cyc++;
        if (bus.tx_valid !== 1'b1) begin
            hold = 0;
            bus.tx_ready = !bp_mode;
        end else if (bp_mode && hold < 5) begin
            bus.tx_ready = 1'b0;
            hold++;
        end else begin
            bus.tx_ready = 1'b1;
        end
        if (rst_n && prev_valid && !prev_ready)
            chk("tx_hold", {55'd0, bus.tx_valid, bus.tx_data}, {55'd0, 1'b1, prev_data});
        if (bus.tx_valid === 1'b1 && bus.tx_ready) begin
            tx_q.push_back(bus.tx_data);
            hold = 0;
        end
        prev_valid = (bus.tx_valid === 1'b1);
        prev_ready = bus.tx_ready;
        prev_data  = bus.tx_data;
    end

    function automatic logic [63:0] all_outs();
        return {8'd0, bus.tx_data, bus.tx_valid, bus.load_done, bus.dump_done,
                bus.M_I_data_UART, bus.M_I_addr_UART, bus.M_I_we_UART,
                bus.MI_IMG_data_UART, bus.MI_IMG_addr_UART, bus.MI_IMG_we_UART};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_cpu_done();
        bus.cpu_done = 1'b1;
        @(negedge clk);
        bus.cpu_done = 1'b0;
    endtask

    // Reference: first INS_BYTES stream bytes are the program, the next IMG_IN_BYTES the image.
    task automatic do_load(input logic [7:0] bytes [12], input int gap, input string tag);
        for (int i = 0; i < 4; i++) ins_mem[i] = 8'hEE;
        for (int i = 0; i < 8; i++) img_mem[i] = 8'hEE;
        ins_we_cyc = 0;
        img_we_cyc = 0;
        for (int i = 0; i < INS_BYTES + IMG_IN_BYTES; i++) begin
            if (i == INS_BYTES + IMG_IN_BYTES - 1)
                chk({tag, "_load_done_early"}, {63'd0, bus.load_done}, 64'd0);
            send_byte(bytes[i], gap);
        end
        if (gap == 0) chk({tag, "_load_done"}, {63'd0, bus.load_done}, 64'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_load_done_lvl"}, {63'd0, bus.load_done}, 64'd1);
        for (int i = 0; i < INS_BYTES; i++)
            chk($sformatf("%s_ins%0d", tag, i), {56'd0, ins_mem[i]}, {56'd0, bytes[i]});
        for (int i = 0; i < IMG_IN_BYTES; i++)
            chk($sformatf("%s_img%0d", tag, i), {56'd0, img_mem[i]}, {56'd0, bytes[INS_BYTES + i]});
        chk({tag, "_ins_we_cycles"}, 64'(ins_we_cyc), 64'(INS_BYTES));
        chk({tag, "_img_we_cycles"}, 64'(img_we_cyc), 64'(IMG_IN_BYTES));
    endtask

    task automatic do_dump(input logic [7:0] data [4], input bit bp, input string tag);
        logic [7:0] exp_q [$];
        logic [7:0] sum;
        int         wait_cyc;
        int         ins_before;
        int         img_before;
        bp_mode = bp;
        sum = 8'h00;
        for (int i = 0; i < IMG_OUT_BYTES; i++) begin
            img_mem[IMG_OUT_BASE + i] = data[i];
            exp_q.push_back(data[i]);
            sum = sum + data[i];
        end
`ifdef UART_DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        tx_q.delete();
        ins_before = ins_we_cyc;
        img_before = img_we_cyc;
        pulse_cpu_done();
        chk({tag, "_load_done_clr"}, {63'd0, bus.load_done}, 64'd0);
        wait_cyc = 0;
        while (bus.dump_done !== 1'b1 && wait_cyc < 400) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk({tag, "_dump_done_seen"}, {63'd0, bus.dump_done}, 64'd1);
        chk({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i),
                (i < tx_q.size()) ? {56'd0, tx_q[i]} : 64'hDEAD, {56'd0, exp_q[i]});
        @(negedge clk);
        chk({tag, "_dump_done_pulse"}, {63'd0, bus.dump_done}, 64'd0);
        chk({tag, "_no_we_in_dump"}, 64'((ins_we_cyc - ins_before) + (img_we_cyc - img_before)), 64'd0);
        bp_mode = 1'b0;
    endtask

    initial begin
        logic [7:0] ld [12];
        logic [7:0] dd [4];
        int         ins_before;
        int         img_before;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.cpu_done = 1'b0;
        bus.tx_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // cpu_done while idle must not start a dump.
        tx_q.delete();
        pulse_cpu_done();
        repeat (10) @(negedge clk);
        chk("idle_cpu_done_ignored", {62'd0, bus.tx_valid, bus.load_done}, 64'd0);

        // 1. spaced load of 0x01..0x0C
        for (int i = 0; i < 12; i++) ld[i] = 8'(i + 1);
        do_load(ld, 3, "t1");

        // 3. directed dump, tx_ready held high
        dd[0] = 8'hA0; dd[1] = 8'hA1; dd[2] = 8'hA2; dd[3] = 8'hFF;
        do_dump(dd, 1'b0, "t3");

        // 2. back-to-back random load
        for (int i = 0; i < 12; i++) ld[i] = 8'($urandom);
        do_load(ld, 0, "t2");

        // 4. random dump under backpressure
        for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
        do_dump(dd, 1'b1, "t4");

        // 5. reset mid-load, then a fresh load from instruction address 0
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(8'h80, 8'hFF)), 1);
        do_reset();
        for (int i = 0; i < 12; i++) ld[i] = 8'($urandom_range(0, 8'h7F));
        do_load(ld, 2, "t5");
        ins_before = ins_we_cyc;
        img_before = img_we_cyc;
        for (int i = 0; i < 3; i++) send_byte(8'h55, 1);
        repeat (2) @(negedge clk);
        chk("t5_rx_ignored_we", 64'((ins_we_cyc - ins_before) + (img_we_cyc - img_before)), 64'd0);
        chk("t5_rx_ignored_mem", {56'd0, ins_mem[0]}, {56'd0, ld[0]});
        chk("t5_load_done_kept", {63'd0, bus.load_done}, 64'd1);
        for (int i = 0; i < 4; i++) dd[i] = 8'($urandom);
        do_dump(dd, 1'b0, "t5");

        chk("no_out_of_range_writes", 64'(oob_wr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
